// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin packet scheduler in front of one UART transmitter.
// A grant is held for a whole packet; timeouts keep a stuck peer from hanging it.
module uart_tx_sched #(
    parameter int GAP_CYCLES    = 16,
    parameter int START_TIMEOUT = 8,
    parameter int PKT_TIMEOUT   = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  ack,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [1:0]  grant_id,
    output logic        active,
    output logic        err
);
    localparam logic [15:0] GAP_LIM =
        16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [15:0] START_LIM =
        16'((START_TIMEOUT > 0) ? START_TIMEOUT - 1 : 0);
    localparam logic [15:0] PKT_LIM =
        16'((PKT_TIMEOUT > 0) ? PKT_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        IDLE, SEND, WAIT_START, WAIT_DONE, GAP
    } state_t;

    state_t      state;
    logic [1:0]  last_grant;
    logic        last_q;
    logic [15:0] wait_cnt;
    logic [15:0] idle_cnt;
    logic [7:0]  data_q;
    logic [7:0]  cur_byte;
    logic        req_g;
    logic        wr_now;
    logic [1:0]  pick;
    logic        pick_ok;

    assign cur_byte = req_data[8*grant_id +: 8];
    assign req_g    = req[grant_id];

    // The strobe is combinational so the byte is taken in the cycle it is offered.
    assign wr_now  = (state == SEND) && req_g && !tx_busy && !rst;
    assign tx_wr   = wr_now;
    assign ack     = wr_now ? (4'b0001 << grant_id) : 4'b0000;
    assign tx_data = wr_now ? cur_byte : data_q;

    // Highest priority goes to the requester just after the last one served.
    always_comb begin
        pick    = 2'd0;
        pick_ok = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            if (req[2'(last_grant + 2'(k))]) begin
                pick    = 2'(last_grant + 2'(k));
                pick_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 2'd3;
            grant_id   <= 2'd0;
            active     <= 1'b0;
            err        <= 1'b0;
            last_q     <= 1'b0;
            wait_cnt   <= 16'd0;
            idle_cnt   <= 16'd0;
            data_q     <= 8'h00;
        end else begin
            err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_ok) begin
                        grant_id   <= pick;
                        last_grant <= pick;
                        active     <= 1'b1;
                        idle_cnt   <= 16'd0;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (wr_now) begin
                        data_q   <= cur_byte;
                        last_q   <= req_last[grant_id];
                        idle_cnt <= 16'd0;
                        wait_cnt <= 16'd0;
                        state    <= WAIT_START;
                    end else if (!req_g) begin
                        if (idle_cnt == PKT_LIM) begin
                            err      <= 1'b1;
                            active   <= 1'b0;
                            idle_cnt <= 16'd0;
                            wait_cnt <= 16'd0;
                            state    <= GAP;
                        end else begin
                            idle_cnt <= idle_cnt + 16'd1;
                        end
                    end
                end
                WAIT_START: begin
                    if (tx_busy || wait_cnt == START_LIM) begin
                        wait_cnt <= 16'd0;
                        state    <= WAIT_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (last_q) begin
                            active <= 1'b0;
                            state  <= GAP;
                        end else begin
                            state <= SEND;
                        end
                    end
                end
                GAP: begin
                    if (wait_cnt == GAP_LIM) begin
                        wait_cnt <= 16'd0;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: scoreboard bench with queued requesters and a model UART.
// Expected byte order comes from a packet-level round-robin model.
module tb_uart_tx_sched;
    localparam int G  = 4;
    localparam int ST = 8;
    localparam int PT = 20;
    localparam int B  = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  ack;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        active;
    logic        err;

    uart_tx_sched #(
        .GAP_CYCLES(G), .START_TIMEOUT(ST), .PKT_TIMEOUT(PT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .req_last(req_last), .ack(ack), .tx_data(tx_data),
        .tx_wr(tx_wr), .tx_busy(tx_busy), .grant_id(grant_id),
        .active(active), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] data; logic last; } byte_t;
    typedef struct packed { logic [1:0] id; logic [7:0] data; } exp_t;

    byte_t rq[4][$];
    byte_t mq[4][$];
    exp_t  exp_q[$];
    int    wr_hist[$];
    int    mlg;
    int    cyc = 0;
    int    n_chk = 0;
    int    n_fail = 0;
    int    err_cnt = 0;
    int    err_cyc = 0;
    int    bcnt = 0;
    bit    nobusy = 0;
    bit    rand_busy = 0;
    logic [3:0] ack_s = 4'b0;
    logic  wr_s = 1'b0;
    exp_t  me;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req_v);
        n_chk++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req_v);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Requesters and model transmitter, driven just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (ack_s[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (wr_s)
            bcnt = nobusy ? 0 : (rand_busy ? int'($urandom_range(2, 12)) : B);
        else if (bcnt > 0)
            bcnt--;
        tx_busy = (bcnt > 0);
        for (int i = 0; i < 4; i++) begin
            req[i] = (rq[i].size() > 0);
            req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0].data : 8'h00;
            req_last[i] = (rq[i].size() > 0) ? rq[i][0].last : 1'b0;
        end
    end

    // Monitor: pops the scoreboard on every write strobe.
    initial forever begin
        @(negedge clk);
        ack_s = ack;
        wr_s  = tx_wr;
        chk("ack_iff_wr", 32'(ack != 4'b0), 32'(tx_wr));
        if (tx_wr) begin
            wr_hist.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
                me = exp_q.pop_front();
                chk("wr_id", 32'(grant_id), 32'(me.id));
                chk("wr_data", 32'(tx_data), 32'(me.data));
                chk("wr_ack", 32'(ack), 32'(4'b0001 << me.id));
                chk("wr_active", 32'(active), 32'd1);
            end
        end
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic push_byte(input int id, input logic [7:0] d,
                             input logic l);
        byte_t b;
        b.data = d;
        b.last = l;
        rq[id].push_back(b);
        mq[id].push_back(b);
    endtask

    task automatic load_pkt(input int id, input int len);
        for (int k = 0; k < len; k++)
            push_byte(id, 8'($urandom), k == len - 1);
    endtask

    // Whole-packet round robin over whatever is queued.
    task automatic model_run();
        int    g;
        bit    any;
        byte_t b;
        exp_t  e;
        any = 1;
        while (any) begin
            g = -1;
            for (int k = 1; k <= 4; k++)
                if (g < 0 && mq[(mlg + k) % 4].size() > 0) g = (mlg + k) % 4;
            any = (g >= 0);
            if (any) begin
                b.last = 0;
                while (!b.last && mq[g].size() > 0) begin
                    b = mq[g].pop_front();
                    e.id = 2'(g);
                    e.data = b.data;
                    exp_q.push_back(e);
                end
                mlg = g;
            end
        end
    endtask

    function automatic bit rq_empty();
        bit r;
        r = 1;
        for (int i = 0; i < 4; i++) if (rq[i].size() > 0) r = 0;
        return r;
    endfunction

    task automatic chk_reset(input string nm);
        chk({nm, "_ack"}, 32'(ack), 32'd0);
        chk({nm, "_wr"}, 32'(tx_wr), 32'd0);
        chk({nm, "_data"}, 32'(tx_data), 32'd0);
        chk({nm, "_gid"}, 32'(grant_id), 32'd0);
        chk({nm, "_active"}, 32'(active), 32'd0);
        chk({nm, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rq[i].delete();
            mq[i].delete();
        end
        exp_q.delete();
        wr_hist.delete();
        err_cnt = 0;
        mlg = 3;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_wr(input string nm, input int n, input int budget);
        int k;
        k = 0;
        while (wr_hist.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 32'(wr_hist.size() >= n), 32'd1);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic drain(input string nm, input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || !rq_empty()) && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (30) @(negedge clk);
        chk({nm, "_left"}, 32'(exp_q.size()), 32'd0);
        chk({nm, "_idle"}, 32'(active), 32'd0);
    endtask

    initial begin
        logic [7:0] keep[3];
        int t;
        int total;
        rst = 1'b1;
        req = 4'b0;
        req_data = 32'b0;
        req_last = 4'b0;
        tx_busy = 1'b0;
        mlg = 3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Single requester, three bytes.
        push_byte(1, 8'h41, 1'b0);
        push_byte(1, 8'h42, 1'b0);
        push_byte(1, 8'h43, 1'b1);
        model_run();
        wait_wr("single_wr", 3, 200);
        t = wr_hist[2];
        wait_cyc(t + B + 1);
        chk("single_active_hi", 32'(active), 32'd1);
        chk("single_gid", 32'(grant_id), 32'd1);
        @(negedge clk);
        chk("single_active_lo", 32'(active), 32'd0);
        drain("single", 100);

        // Fairness: everyone always requesting, 1-byte packets.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) load_pkt(i, 1);
        model_run();
        wait_wr("fair_wr", 8, 600);
        for (int k = 1; k < 8; k++)
            chk("fair_gap", 32'(wr_hist[k] - wr_hist[k-1]), 32'(B + G + 3));
        drain("fair", 100);

        // Lock: others arrive mid-packet and must wait.
        do_reset();
        load_pkt(2, 4);
        model_run();
        wait_wr("lock_first", 1, 100);
        load_pkt(0, 1);
        load_pkt(3, 1);
        model_run();
        wait_wr("lock_wr", 6, 600);
        drain("lock", 200);

        // Stall: requester vanishes after its first byte.
        do_reset();
        push_byte(0, 8'h5A, 1'b0);
        model_run();
        wait_wr("stall_wr", 1, 100);
        t = wr_hist[0];
        begin
            int k;
            k = 0;
            while (err_cnt == 0 && k < 200) begin
                @(negedge clk);
                k++;
            end
        end
        chk("stall_err_seen", 32'(err_cnt), 32'd1);
        chk("stall_err_time", 32'(err_cyc - t), 32'(B + 2 + PT));
        chk("stall_active", 32'(active), 32'd0);
        repeat (40) @(negedge clk);
        chk("stall_err_once", 32'(err_cnt), 32'd1);
        chk("stall_no_more_wr", 32'(wr_hist.size()), 32'd1);

        // Transmitter never raises busy.
        do_reset();
        nobusy = 1;
        load_pkt(1, 3);
        model_run();
        wait_wr("nobusy_wr", 3, 200);
        chk("nobusy_gap1", 32'(wr_hist[1] - wr_hist[0]), 32'(ST + 2));
        chk("nobusy_gap2", 32'(wr_hist[2] - wr_hist[1]), 32'(ST + 2));
        drain("nobusy", 100);
        nobusy = 0;

        // Reset in the middle of the second byte's frame.
        do_reset();
        for (int k = 0; k < 3; k++) keep[k] = 8'($urandom);
        for (int k = 0; k < 3; k++) push_byte(2, keep[k], k == 2);
        model_run();
        wait_wr("rst_wr2", 2, 200);
        @(negedge clk);
        exp_q.delete();
        rq[2].delete();
        mq[2].delete();
        mlg = 3;
        load_pkt(0, 2);
        for (int k = 0; k < 3; k++) push_byte(2, keep[k], k == 2);
        model_run();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset("midrst");
        wait_wr("rst_wr_after", 7, 400);
        drain("midrst", 200);

        // Randomised traffic with varying frame lengths.
        rand_busy = 1;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < 4; i++)
                repeat ($urandom_range(0, 3)) load_pkt(i, $urandom_range(1, 4));
            load_pkt($urandom_range(0, 3), $urandom_range(1, 4));
            model_run();
            total = exp_q.size();
            wait_wr("rand_wr", total, total * 40 + 200);
            drain("rand", 400);
            chk("rand_no_err", 32'(err_cnt), 32'd0);
        end
        rand_busy = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
